// File: rtl/axi_lite_buffer_if.sv
// axi_lite_channel: AXI-Lite bundle carrying the five channels (AW, W, B, AR, R).
//   clk, rstn : bundle-level clock/reset, carried for the surrounding system only.
//   master    : drives AW/W/AR payload+valid and B/R ready.
//   slave     : drives AW/W/AR ready and B/R payload+valid.
interface axi_lite_channel #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64
) (
    input logic clk,
    input logic rstn
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]              aw_prot;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;

    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;

    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]              ar_prot;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_addr, aw_prot, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input b_resp, b_valid, output b_ready,
        output ar_addr, ar_prot, ar_valid, input ar_ready,
        input r_data, r_resp, r_valid, output r_ready
    );

    modport slave (
        input aw_addr, aw_prot, aw_valid, output aw_ready,
        input w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input ar_addr, ar_prot, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );
endinterface

// File: rtl/axi_lite_buffer.sv
// axi_lite_buffer: per-channel FIFO buffering between an AXI-Lite master and slave.
//   clk    : sole clock.
//   rst    : synchronous active-high reset; discards all held beats.
//   host   : upstream side (AW/W/AR in, B/R out).
//   device : downstream side (AW/W/AR out, B/R in).
//   idle   : high when no beat is held in any channel.
// A channel depth of 0 is a pure wire; depth >= 1 is a registered FIFO with no
// bypass, so ready and valid on either side come from registered state only.

// axi_lite_buffer_fifo: registered FIFO, DEPTH >= 1 entries of WIDTH bits.
//   in_valid_i/in_ready_o/in_data_i    : write side.
//   out_valid_o/out_ready_i/out_data_o : read side, head entry.
//   empty_o                            : no entries held.
module axi_lite_buffer_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             push;
    logic             pop;

    // Handshake outputs are gated by rst so both sides see a quiet bus while
    // reset is held, even before the first reset edge has cleared the count.
    assign in_ready_o  = !rst_i && (count_q != FULL_CNT);
    assign out_valid_o = !rst_i && (count_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign empty_o     = (count_q == '0);

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Payload storage carries no reset; contents are only observed under valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end
endmodule

module axi_lite_buffer #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int AW_DEPTH   = 2,
    parameter int W_DEPTH    = 2,
    parameter int B_DEPTH    = 2,
    parameter int AR_DEPTH   = 2,
    parameter int R_DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    axi_lite_channel.slave   host,
    axi_lite_channel.master  device,
    output logic             idle
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int AX_W       = ADDR_WIDTH + 3;
    localparam int W_W        = DATA_WIDTH + STRB_WIDTH;
    localparam int R_W        = DATA_WIDTH + 2;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
        $fatal(1, "axi_lite_buffer: DATA_WIDTH must be 32 or 64");
    end
    if (AW_DEPTH < 0 || AW_DEPTH > 16 || W_DEPTH < 0 || W_DEPTH > 16 ||
        B_DEPTH < 0 || B_DEPTH > 16 || AR_DEPTH < 0 || AR_DEPTH > 16 ||
        R_DEPTH < 0 || R_DEPTH > 16) begin : g_bad_depth
        $fatal(1, "axi_lite_buffer: channel depths must be in 0..16");
    end

    logic aw_empty, w_empty, b_empty, ar_empty, r_empty;

    // ---------------- AW: host -> device ----------------
    if (AW_DEPTH == 0) begin : g_aw_pass
        assign device.aw_addr  = host.aw_addr;
        assign device.aw_prot  = host.aw_prot;
        assign device.aw_valid = host.aw_valid;
        assign host.aw_ready   = device.aw_ready;
        assign aw_empty        = 1'b1;
    end else begin : g_aw_fifo
        logic [AX_W-1:0] out_data;
        axi_lite_buffer_fifo #(.DEPTH(AW_DEPTH), .WIDTH(AX_W)) u_fifo (
            .clk_i       (clk),
            .rst_i       (rst),
            .in_valid_i  (host.aw_valid),
            .in_ready_o  (host.aw_ready),
            .in_data_i   ({host.aw_addr, host.aw_prot}),
            .out_valid_o (device.aw_valid),
            .out_ready_i (device.aw_ready),
            .out_data_o  (out_data),
            .empty_o     (aw_empty)
        );
        assign {device.aw_addr, device.aw_prot} = out_data;
    end

    // ---------------- W: host -> device ----------------
    if (W_DEPTH == 0) begin : g_w_pass
        assign device.w_data  = host.w_data;
        assign device.w_strb  = host.w_strb;
        assign device.w_valid = host.w_valid;
        assign host.w_ready   = device.w_ready;
        assign w_empty        = 1'b1;
    end else begin : g_w_fifo
        logic [W_W-1:0] out_data;
        axi_lite_buffer_fifo #(.DEPTH(W_DEPTH), .WIDTH(W_W)) u_fifo (
            .clk_i       (clk),
            .rst_i       (rst),
            .in_valid_i  (host.w_valid),
            .in_ready_o  (host.w_ready),
            .in_data_i   ({host.w_data, host.w_strb}),
            .out_valid_o (device.w_valid),
            .out_ready_i (device.w_ready),
            .out_data_o  (out_data),
            .empty_o     (w_empty)
        );
        assign {device.w_data, device.w_strb} = out_data;
    end

    // ---------------- B: device -> host ----------------
    if (B_DEPTH == 0) begin : g_b_pass
        assign host.b_resp     = device.b_resp;
        assign host.b_valid    = device.b_valid;
        assign device.b_ready  = host.b_ready;
        assign b_empty         = 1'b1;
    end else begin : g_b_fifo
        axi_lite_buffer_fifo #(.DEPTH(B_DEPTH), .WIDTH(2)) u_fifo (
            .clk_i       (clk),
            .rst_i       (rst),
            .in_valid_i  (device.b_valid),
            .in_ready_o  (device.b_ready),
            .in_data_i   (device.b_resp),
            .out_valid_o (host.b_valid),
            .out_ready_i (host.b_ready),
            .out_data_o  (host.b_resp),
            .empty_o     (b_empty)
        );
    end

    // ---------------- AR: host -> device ----------------
    if (AR_DEPTH == 0) begin : g_ar_pass
        assign device.ar_addr  = host.ar_addr;
        assign device.ar_prot  = host.ar_prot;
        assign device.ar_valid = host.ar_valid;
        assign host.ar_ready   = device.ar_ready;
        assign ar_empty        = 1'b1;
    end else begin : g_ar_fifo
        logic [AX_W-1:0] out_data;
        axi_lite_buffer_fifo #(.DEPTH(AR_DEPTH), .WIDTH(AX_W)) u_fifo (
            .clk_i       (clk),
            .rst_i       (rst),
            .in_valid_i  (host.ar_valid),
            .in_ready_o  (host.ar_ready),
            .in_data_i   ({host.ar_addr, host.ar_prot}),
            .out_valid_o (device.ar_valid),
            .out_ready_i (device.ar_ready),
            .out_data_o  (out_data),
            .empty_o     (ar_empty)
        );
        assign {device.ar_addr, device.ar_prot} = out_data;
    end

    // ---------------- R: device -> host ----------------
    if (R_DEPTH == 0) begin : g_r_pass
        assign host.r_data     = device.r_data;
        assign host.r_resp     = device.r_resp;
        assign host.r_valid    = device.r_valid;
        assign device.r_ready  = host.r_ready;
        assign r_empty         = 1'b1;
    end else begin : g_r_fifo
        logic [R_W-1:0] out_data;
        axi_lite_buffer_fifo #(.DEPTH(R_DEPTH), .WIDTH(R_W)) u_fifo (
            .clk_i       (clk),
            .rst_i       (rst),
            .in_valid_i  (device.r_valid),
            .in_ready_o  (device.r_ready),
            .in_data_i   ({device.r_data, device.r_resp}),
            .out_valid_o (host.r_valid),
            .out_ready_i (host.r_ready),
            .out_data_o  (out_data),
            .empty_o     (r_empty)
        );
        assign {host.r_data, host.r_resp} = out_data;
    end

    // rst is folded in so idle reads 1 before the first reset edge clears counts.
    assign idle = rst || (aw_empty && w_empty && b_empty && ar_empty && r_empty);
endmodule

// File: tb/tb_axi_lite_buffer.sv
module tb_axi_lite_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic idle, idle0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    axi_lite_channel #(.ADDR_WIDTH(48), .DATA_WIDTH(64)) h  (.clk(clk), .rstn(~rst));
    axi_lite_channel #(.ADDR_WIDTH(48), .DATA_WIDTH(64)) d  (.clk(clk), .rstn(~rst));
    axi_lite_channel #(.ADDR_WIDTH(48), .DATA_WIDTH(64)) h0 (.clk(clk), .rstn(~rst));
    axi_lite_channel #(.ADDR_WIDTH(48), .DATA_WIDTH(64)) d0 (.clk(clk), .rstn(~rst));

    axi_lite_buffer #(
        .ADDR_WIDTH(48), .DATA_WIDTH(64),
        .AW_DEPTH(2), .W_DEPTH(2), .B_DEPTH(2), .AR_DEPTH(4), .R_DEPTH(1)
    ) dut (
        .clk(clk), .rst(rst), .host(h), .device(d), .idle(idle)
    );

    axi_lite_buffer #(
        .ADDR_WIDTH(48), .DATA_WIDTH(64),
        .AW_DEPTH(0), .W_DEPTH(2), .B_DEPTH(2), .AR_DEPTH(2), .R_DEPTH(2)
    ) dut0 (
        .clk(clk), .rst(rst), .host(h0), .device(d0), .idle(idle0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        // quiet bus on both DUTs
        h.aw_addr = '0; h.aw_prot = '0; h.aw_valid = 0;
        h.w_data = '0; h.w_strb = '0; h.w_valid = 0;
        h.b_ready = 0;
        h.ar_addr = '0; h.ar_prot = '0; h.ar_valid = 0;
        h.r_ready = 0;
        d.aw_ready = 0; d.w_ready = 0; d.ar_ready = 0;
        d.b_resp = '0; d.b_valid = 0;
        d.r_data = '0; d.r_resp = '0; d.r_valid = 0;
        h0.aw_addr = '0; h0.aw_prot = '0; h0.aw_valid = 0;
        h0.w_data = '0; h0.w_strb = '0; h0.w_valid = 0;
        h0.b_ready = 0;
        h0.ar_addr = '0; h0.ar_prot = '0; h0.ar_valid = 0;
        h0.r_ready = 0;
        d0.aw_ready = 0; d0.w_ready = 0; d0.ar_ready = 0;
        d0.b_resp = '0; d0.b_valid = 0;
        d0.r_data = '0; d0.r_resp = '0; d0.r_valid = 0;

        // reset held 3 cycles with AW valid driven
        h.aw_valid = 1; h.aw_addr = 48'h1000; h.aw_prot = 3'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_aw_ready", h.aw_ready, 0);
            chk("rst_w_ready", h.w_ready, 0);
            chk("rst_ar_ready", h.ar_ready, 0);
            chk("rst_b_ready", d.b_ready, 0);
            chk("rst_r_ready", d.r_ready, 0);
            chk("rst_dev_aw_valid", d.aw_valid, 0);
            chk("rst_host_r_valid", h.r_valid, 0);
            chk("rst_idle", idle, 1);
        end
        rst = 0;
        #1;
        chk("post_rst_aw_ready", h.aw_ready, 1);
        chk("post_rst_w_ready", h.w_ready, 1);
        chk("post_rst_ar_ready", h.ar_ready, 1);
        chk("post_rst_b_ready", d.b_ready, 1);
        chk("post_rst_r_ready", d.r_ready, 1);
        chk("post_rst_idle", idle, 1);
        tick();  // AW 0x1000 pushed
        h.aw_valid = 0;
        chk("aw_lat_valid", d.aw_valid, 1);
        chk("aw_lat_addr", d.aw_addr, 64'h1000);
        chk("aw_lat_prot", d.aw_prot, 2);
        chk("aw_idle_busy", idle, 0);
        d.aw_ready = 1;
        tick();  // popped
        chk("aw_drained", d.aw_valid, 0);
        chk("aw_idle_again", idle, 1);
        d.aw_ready = 0;

        // streaming W, depth 2
        d.w_ready = 1;
        h.w_valid = 1; h.w_strb = 8'hFF; h.w_data = 64'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("w_stream_valid", d.w_valid, 1);
            chk("w_stream_data", d.w_data, 64'(i));
            chk("w_stream_strb", d.w_strb, 64'hFF);
            chk("w_stream_ready", h.w_ready, 1);
            if (i < 7) h.w_data = 64'(i + 1);
            else h.w_valid = 0;
        end
        tick();
        chk("w_stream_end", d.w_valid, 0);
        d.w_ready = 0;

        // backpressure AR, depth 4
        h.ar_valid = 1; h.ar_prot = 3'd0;
        for (int j = 0; j < 4; j++) begin
            h.ar_addr = 48'h100 + 48'(8 * j);
            #1;
            chk("ar_accept_ready", h.ar_ready, 1);
            tick();
        end
        h.ar_addr = 48'h120;
        #1;
        chk("ar_full_ready", h.ar_ready, 0);
        tick();
        chk("ar_full_hold", h.ar_ready, 0);
        chk("ar_full_dvalid", d.ar_valid, 1);
        chk("ar_full_head", d.ar_addr, 64'h100);
        d.ar_ready = 1;
        #1;
        chk("ar_pop_still_full", h.ar_ready, 0);
        tick();
        chk("ar_out1", d.ar_addr, 64'h108);
        chk("ar_ready_back", h.ar_ready, 1);
        tick();  // 0x120 accepted here
        h.ar_valid = 0;
        chk("ar_out2", d.ar_addr, 64'h110);
        tick();
        chk("ar_out3", d.ar_addr, 64'h118);
        tick();
        chk("ar_out4_valid", d.ar_valid, 1);
        chk("ar_out4", d.ar_addr, 64'h120);
        tick();
        chk("ar_drained", d.ar_valid, 0);
        d.ar_ready = 0;

        // B full with simultaneous pop, depth 2
        d.b_valid = 1; d.b_resp = 2'd0;
        #1;
        chk("b_fill0_ready", d.b_ready, 1);
        tick();
        d.b_resp = 2'd2;
        #1;
        chk("b_fill1_ready", d.b_ready, 1);
        tick();
        d.b_resp = 2'd1;
        h.b_ready = 1;
        #1;
        chk("b_full_ready", d.b_ready, 0);
        chk("b_head_valid", h.b_valid, 1);
        chk("b_head_okay", h.b_resp, 0);
        tick();
        chk("b_ready_next", d.b_ready, 1);
        chk("b_head_slverr", h.b_resp, 2);
        tick();
        d.b_valid = 0;
        chk("b_new_valid", h.b_valid, 1);
        chk("b_new_resp", h.b_resp, 1);
        tick();
        chk("b_drained", h.b_valid, 0);
        h.b_ready = 0;

        // R depth 1, alternating acceptance
        h.r_ready = 1;
        d.r_valid = 1; d.r_resp = 2'd0; d.r_data = 64'hA0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("r_in_ready_hi", d.r_ready, 1);
            chk("r_out_empty", h.r_valid, 0);
            tick();
            chk("r_in_ready_lo", d.r_ready, 0);
            chk("r_out_valid", h.r_valid, 1);
            chk("r_out_data", h.r_data, 64'hA0 + 64'(k));
            if (k < 3) d.r_data = 64'hA0 + 64'(k + 1);
            else d.r_valid = 0;
            tick();
        end
        chk("r_drained", h.r_valid, 0);
        h.r_ready = 0;

        // depth-0 AW on dut0: ready mirrors combinationally
        h0.aw_valid = 1; h0.aw_prot = 3'd5;
        for (int i = 0; i < 4; i++) begin
            h0.aw_addr = 48'hABC + 48'(i);
            d0.aw_ready = (i % 2 == 1);
            #1;
            chk("aw0_ready_mirror", h0.aw_ready, 64'(i % 2));
            chk("aw0_valid", d0.aw_valid, 1);
            chk("aw0_addr", d0.aw_addr, 64'hABC + 64'(i));
            chk("aw0_prot", d0.aw_prot, 5);
            tick();
        end
        h0.aw_valid = 0;
        #1;
        chk("aw0_valid_off", d0.aw_valid, 0);

        // reset mid-operation discards held beats
        h.w_valid = 1; h.w_data = 64'h55; h.w_strb = 8'h0F;
        tick();
        h.w_valid = 0;
        chk("mid_held_valid", d.w_valid, 1);
        chk("mid_busy", idle, 0);
        rst = 1;
        #1;
        chk("mid_rst_gate", d.w_valid, 0);
        chk("mid_rst_idle", idle, 1);
        tick();
        rst = 0;
        #1;
        chk("mid_after_valid", d.w_valid, 0);
        chk("mid_after_idle", idle, 1);
        chk("mid_after_ready", h.w_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
